// File: rtl/i2s_frame_serializer_if.sv
// Frame handshake between the effect chain and the I2S output serializer.
interface i2s_frame_serializer_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
    logic              fvalid;
    logic              fready;

    modport master (output left, output right, output fvalid, input fready);
    modport slave  (input left, input right, input fvalid, output fready);
endinterface

// File: rtl/i2s_frame_serializer.sv
// I2S transmit stage: one-frame holding buffer feeding an MSB-first shifter
// timed by mclk-sampled sclk/lrclk; silence and a pulse on missing frames.
module i2s_frame_serializer #(
    parameter int DATA_W = 24
) (
    input  logic                  mclk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  lrclk,
    i2s_frame_serializer_if.slave frame,
    output logic                  sdout,
    output logic                  underrun,
    output logic                  slot_err
);
    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    logic              sclk_d_q, sclk_d_d;
    logic              lr_prev_q, lr_prev_d;
    logic              armed_q, armed_d;
    logic              hold_v_q, hold_v_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d;
    logic [DATA_W-1:0] hold_r_q, hold_r_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              sdout_q, sdout_d;
    logic              underrun_q, underrun_d;
    logic              slot_err_q, slot_err_d;

    logic sfall_s, bnd_s, left_bnd_s, accept_s;

    // Next-state logic: edge detect, slot boundaries, shifting and the holding buffer.
    always_comb begin
        sfall_s    = sclk_d_q & ~sclk;
        bnd_s      = sfall_s & (lrclk != lr_prev_q);
        left_bnd_s = bnd_s & ~lrclk;
        accept_s   = frame.fvalid & ~hold_v_q;

        sclk_d_d   = sclk;
        lr_prev_d  = lr_prev_q;
        armed_d    = armed_q;
        hold_v_d   = hold_v_q;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        shift_d    = shift_q;
        rbuf_d     = rbuf_q;
        bit_cnt_d  = bit_cnt_q;
        sdout_d    = sdout_q;
        underrun_d = 1'b0;
        slot_err_d = 1'b0;

        if (sfall_s) begin
            lr_prev_d = lrclk;
        end else begin
            lr_prev_d = lr_prev_q;
        end

        // The boundary bit itself is the zero padding that yields the one-bit I2S delay.
        if (bnd_s) begin
            sdout_d    = 1'b0;
            bit_cnt_d  = {CNT_W{1'b0}};
            slot_err_d = armed_q & (bit_cnt_q < CNT_FULL);
            if (left_bnd_s) begin
                armed_d = 1'b1;
                if (hold_v_q) begin
                    shift_d  = hold_l_q;
                    rbuf_d   = hold_r_q;
                    hold_v_d = 1'b0;
                end else begin
                    shift_d    = {DATA_W{1'b0}};
                    rbuf_d     = {DATA_W{1'b0}};
                    underrun_d = armed_q;
                end
            end else if (armed_q) begin
                shift_d = rbuf_q;
            end else begin
                shift_d = shift_q;
            end
        end else if (sfall_s && armed_q) begin
            sdout_d = shift_q[DATA_W-1];
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
            if (bit_cnt_q != CNT_FULL) begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end else begin
                bit_cnt_d = bit_cnt_q;
            end
        end else begin
            sdout_d = sdout_q;
        end

        // A same-cycle left boundary already saw hold_v low, so the new frame waits a frame.
        if (accept_s) begin
            hold_v_d = 1'b1;
            hold_l_d = frame.left;
            hold_r_d = frame.right;
        end else begin
            hold_l_d = hold_l_q;
            hold_r_d = hold_r_q;
        end
    end

    // State and output registers.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            sclk_d_q   <= 1'b0;
            lr_prev_q  <= 1'b0;
            armed_q    <= 1'b0;
            hold_v_q   <= 1'b0;
            hold_l_q   <= {DATA_W{1'b0}};
            hold_r_q   <= {DATA_W{1'b0}};
            shift_q    <= {DATA_W{1'b0}};
            rbuf_q     <= {DATA_W{1'b0}};
            bit_cnt_q  <= {CNT_W{1'b0}};
            sdout_q    <= 1'b0;
            underrun_q <= 1'b0;
            slot_err_q <= 1'b0;
        end else begin
            sclk_d_q   <= sclk_d_d;
            lr_prev_q  <= lr_prev_d;
            armed_q    <= armed_d;
            hold_v_q   <= hold_v_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            shift_q    <= shift_d;
            rbuf_q     <= rbuf_d;
            bit_cnt_q  <= bit_cnt_d;
            sdout_q    <= sdout_d;
            underrun_q <= underrun_d;
            slot_err_q <= slot_err_d;
        end
    end

    assign frame.fready = ~hold_v_q;
    assign sdout        = sdout_q;
    assign underrun     = underrun_q;
    assign slot_err     = slot_err_q;
endmodule

// File: doc/i2s_frame_serializer.md
# i2s_frame_serializer

Output-side I2S stage of the pedal: accepts processed stereo frames (24-bit left/right words) through a valid/ready handshake and shifts them out MSB-first on `sdout`. Timing comes from the same `sclk`/`lrclk` pair that `i2s_clock_divider` produces for the receive path. `sclk` and `lrclk` are `mclk`-synchronous and are sampled in the `mclk` domain. A one-frame holding buffer decouples the effect chain from slot timing. Missing frames are replaced by silence and flagged.

## Interface
- `DATA_W`, 24: sample width in bits; each slot must be ≥ `DATA_W`+1 `sclk` periods.
- `mclk` in 1: the only clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `sclk` in 1: bit clock from `i2s_clock_divider`, registered on `mclk`, period ≥ 4 `mclk`.
- `lrclk` in 1: word select; 0 = left, 1 = right; changes on `sclk` falling edge.
- `left` in `DATA_W`: left sample, two's complement.
- `right` in `DATA_W`: right sample.
- `fvalid` in 1: frame offered.
- `fready` out 1: holding buffer empty; transfer when `fvalid` && `fready`.
- `sdout` out 1: serial data, registered.
- `underrun` out 1: one-cycle pulse, left slot started with no frame held.
- `slot_err` out 1: one-cycle pulse, slot ended before all `DATA_W` bits were sent.

## Operation
- Edge detect:
  - Register `sclk_d` <= `sclk`.
  - `sfall` = `sclk_d` & ~`sclk`.
  - On every `sfall`, sample `lrclk` into `lr_prev`.
  - A boundary occurs when `lrclk` != `lr_prev` at an `sfall`.
- Holding buffer:
  - Contains `hold_l`, `hold_r` and `hold_v`.
  - `fready` = ~`hold_v`.
  - An accept writes both words and sets `hold_v`.
- Arming:
  - `armed` is 0 after reset.
  - The first falling `lrclk` boundary sets `armed`.
  - While unarmed: `sdout` = 0, right boundaries ignored, no `underrun`/`slot_err`.
- Left boundary (`lrclk` 1→0):
  - If `hold_v`: `shift` <= `hold_l`, `rbuf` <= `hold_r`, clear `hold_v`.
  - Else: `shift` <= 0, `rbuf` <= 0, pulse `underrun`.
- Right boundary (`lrclk` 0→1): `shift` <= `rbuf`.
- At any boundary:
  - `sdout` <= 0. This is the final padding bit of the previous slot, giving the I2S one-bit delay.
  - `bit_cnt` <= 0.
  - If armed and `bit_cnt` < `DATA_W` before clearing, pulse `slot_err`.
- Non-boundary `sfall` while armed:
  - `sdout` <= `shift[DATA_W-1]`.
  - `shift` <= `shift` << 1 (zero fill).
  - `bit_cnt` saturates at `DATA_W`.
  - Bits beyond `DATA_W` are therefore 0.
- Accept and left boundary in the same cycle (only possible with `hold_v` = 0):
  - The boundary takes the underrun path.
  - The accepted frame is stored and played in the next frame.
- Reset mid-operation:
  - All state clears and the held frame is discarded.
  - The block re-arms on the next falling `lrclk` boundary.

## Timing
- Reset values:
  - `sdout` = 0, `fready` = 1, `underrun` = 0, `slot_err` = 0.
  - `shift`, `rbuf`, `hold_*` = 0; `bit_cnt` = 0; `armed` = 0.
  - `sclk_d` = 0, `lr_prev` = 0.
- `sdout` updates on the `mclk` edge where `sfall` is detected, i.e. one `mclk` after the `sclk` falling edge is visible. It is stable across the following `sclk` rising edge.
- MSB of a word appears on the second `sfall` of its slot. The LSB appears on the (`DATA_W`+1)th `sfall`.
- `fready`:
  - Falls on the `mclk` edge after an accept.
  - Rises on the `mclk` edge after the consuming left boundary.
- Accept latency: a frame accepted before a left boundary is output in that frame. Otherwise it waits for the next left boundary (≤ one frame + 1 `mclk`).
- `underrun` and `slot_err` are registered and high for exactly one `mclk`.

## Test plan
- Reset:
  - Stimulus: hold `rst` for 3 `mclk` with toggling clocks.
  - Response: `sdout` = 0, `fready` = 1, no pulses. Release with no first `lrclk` fall yet → `sdout` stays 0.
- Single frame:
  - Stimulus: left = 24'd50321 (0x00C491), right = 24'd34245 (0x0085C5), offered before the first `lrclk` fall.
  - Response: left slot = 0, then 0x00C491 MSB-first, then zeros. Right slot = 0, then 0x0085C5, then zeros. `fready` low only between accept and the left boundary.
- Extremes:
  - Stimulus: left = 24'd16777215, right = 24'd0.
  - Response: 24 ones, then 24 zeros, at the correct bit positions.
- Underrun:
  - Stimulus: no frame for 2 frames, then a frame offered mid-left-slot.
  - Response: `underrun` pulses twice, `sdout` all 0, and the late frame plays in full starting at the next left boundary.
- Back-to-back:
  - Stimulus: `fvalid` held high with 4 distinct frames.
  - Response: each accepted once, output in order, no `underrun`.
- Short slot / reset mid-word:
  - Stimulus: force `lrclk` toggle after 10 bits → `slot_err` pulses once.
  - Stimulus: assert `rst` at bit 10.
  - Response: `sdout` = 0 immediately, `fready` = 1, and output resumes only after the next `lrclk` fall.
